// File: rtl/softmax_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : softmax_pkg                                               |
// | Description : Shared FP32 constants and sequencer state encodings.      |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
package softmax_pkg;

    localparam int FP_WIDTH = 32;

    typedef logic [FP_WIDTH-1:0] fp32_t;

    localparam fp32_t FP_ZERO = 32'h0000_0000;
    localparam fp32_t FP_ONE  = 32'h3F80_0000;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] ST_LOAD      = 4'd1;
    localparam logic [STATE_W-1:0] ST_EXP_ISSUE = 4'd2;
    localparam logic [STATE_W-1:0] ST_EXP_WAIT  = 4'd3;
    localparam logic [STATE_W-1:0] ST_ACC_ISSUE = 4'd4;
    localparam logic [STATE_W-1:0] ST_ACC_WAIT  = 4'd5;
    localparam logic [STATE_W-1:0] ST_DIV_ISSUE = 4'd6;
    localparam logic [STATE_W-1:0] ST_DIV_WAIT  = 4'd7;
    localparam logic [STATE_W-1:0] ST_DONE      = 4'd8;
    localparam logic [STATE_W-1:0] ST_ERROR     = 4'd9;

endpackage
`default_nettype wire

// File: rtl/softmax_watchdog.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : softmax_watchdog                                          |
// | Description : Cycle counter flagging a unit that never answers.         |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module softmax_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int             CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The issue cycle counts as cycle 0, so expiry lands TIMEOUT-1 cycles after the start pulse.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/softmax_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : softmax_sequencer                                         |
// | Description : Schedules exp, accumulate and divide for one FP32 vector. |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module softmax_sequencer
    import softmax_pkg::*;
#(
    parameter int DATA_SIZE = FP_WIDTH,
    parameter int N_DATA    = 10,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    output logic [DATA_SIZE-1:0] exp_data_o,
    output logic                 exp_start_o,
    input  logic [DATA_SIZE-1:0] exp_result_i,
    input  logic                 exp_valid_i,
    output logic [DATA_SIZE-1:0] add_a_o,
    output logic [DATA_SIZE-1:0] add_b_o,
    output logic                 add_start_o,
    input  logic [DATA_SIZE-1:0] add_result_i,
    input  logic                 add_valid_i,
    output logic [DATA_SIZE-1:0] div_num_o,
    output logic [DATA_SIZE-1:0] div_den_o,
    output logic                 div_start_o,
    input  logic [DATA_SIZE-1:0] div_result_i,
    input  logic                 div_valid_i,
    output logic [DATA_SIZE-1:0] out_data_o,
    output logic [7:0]           out_index_o,
    output logic                 out_valid_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int              IW       = (N_DATA > 1) ? $clog2(N_DATA) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(N_DATA - 1);

    logic [STATE_W-1:0]   state_q,     state_d;
    logic [IW-1:0]        idx_q,       idx_d;
    logic [DATA_SIZE-1:0] sum_q,       sum_d;
    logic [DATA_SIZE-1:0] vec_q [N_DATA];
    logic [DATA_SIZE-1:0] vec_d [N_DATA];
    logic [DATA_SIZE-1:0] exp_data_q,  exp_data_d;
    logic [DATA_SIZE-1:0] add_a_q,     add_a_d;
    logic [DATA_SIZE-1:0] add_b_q,     add_b_d;
    logic [DATA_SIZE-1:0] div_num_q,   div_num_d;
    logic [DATA_SIZE-1:0] div_den_q,   div_den_d;
    logic [DATA_SIZE-1:0] out_data_q,  out_data_d;
    logic [7:0]           out_index_q, out_index_d;
    logic                 out_valid_q, out_valid_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        vec_d       = vec_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    sum_d   = FP_ZERO;
                end
            end
            ST_LOAD: begin
                if (data_valid_i) begin
                    vec_d[idx_q] = data_i;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_EXP_ISSUE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_EXP_ISSUE: state_d = ST_EXP_WAIT;
            ST_EXP_WAIT: begin
                if (exp_valid_i) begin
                    vec_d[idx_q] = exp_result_i;
                    state_d      = ST_ACC_ISSUE;
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ACC_ISSUE: state_d = ST_ACC_WAIT;
            ST_ACC_WAIT: begin
                if (add_valid_i) begin
                    sum_d = add_result_i;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_DIV_ISSUE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_EXP_ISSUE;
                    end
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DIV_ISSUE: state_d = ST_DIV_WAIT;
            ST_DIV_WAIT: begin
                if (div_valid_i) begin
                    out_valid_d = 1'b1;
                    out_data_d  = div_result_i;
                    out_index_d = 8'(idx_q);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DIV_ISSUE;
                    end
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are captured from next-state values on entry to an issue state,
    // so they already reflect the word or sum written in the same cycle.
    always_comb begin
        exp_data_d = exp_data_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        div_num_d  = div_num_q;
        div_den_d  = div_den_q;
        if (state_d == ST_EXP_ISSUE) begin
            exp_data_d = vec_d[idx_d];
        end
        if (state_d == ST_ACC_ISSUE) begin
            add_a_d = sum_d;
            add_b_d = vec_d[idx_d];
        end
        if (state_d == ST_DIV_ISSUE) begin
            div_num_d = vec_d[idx_d];
            div_den_d = sum_d;
        end
    end

    assign wd_clear  = (state_d == ST_EXP_ISSUE) || (state_d == ST_ACC_ISSUE) ||
                       (state_d == ST_DIV_ISSUE) ||
                       ((state_d == ST_LOAD) && (state_q != ST_LOAD));
    assign wd_enable = (state_q == ST_EXP_ISSUE) || (state_q == ST_EXP_WAIT) ||
                       (state_q == ST_ACC_ISSUE) || (state_q == ST_ACC_WAIT) ||
                       (state_q == ST_DIV_ISSUE) || (state_q == ST_DIV_WAIT);

    softmax_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            exp_data_q  <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < N_DATA; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            vec_q       <= vec_d;
            exp_data_q  <= exp_data_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            div_num_q   <= div_num_d;
            div_den_q   <= div_den_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_ready_o = (state_q == ST_LOAD);
    assign exp_start_o  = (state_q == ST_EXP_ISSUE);
    assign add_start_o  = (state_q == ST_ACC_ISSUE);
    assign div_start_o  = (state_q == ST_DIV_ISSUE);
    assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign done_o       = (state_q == ST_DONE);
    assign error_o      = (state_q == ST_ERROR);
    assign exp_data_o   = exp_data_q;
    assign add_a_o      = add_a_q;
    assign add_b_o      = add_b_q;
    assign div_num_o    = div_num_q;
    assign div_den_o    = div_den_q;
    assign out_data_o   = out_data_q;
    assign out_index_o  = out_index_q;
    assign out_valid_o  = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_softmax_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_softmax_sequencer                                      |
// | Description : Self-checking bench with FP32 unit models and scoreboard. |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module tb_softmax_sequencer;
    import softmax_pkg::*;

    localparam int N  = 10;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        data_valid_i = 1'b0;
    logic        data_ready_o;
    logic [31:0] exp_data_o, add_a_o, add_b_o, div_num_o, div_den_o, out_data_o;
    logic        exp_start_o, add_start_o, div_start_o, out_valid_o, busy_o, done_o, error_o;
    logic [7:0]  out_index_o;
    logic [31:0] exp_result_i = '0, add_result_i = '0, div_result_i = '0;
    logic        exp_valid_i = 1'b0, add_vm = 1'b0, div_vm = 1'b0;
    logic        stray_add = 1'b0, stray_div = 1'b0;
    wire         add_valid_i = add_vm | stray_add;
    wire         div_valid_i = div_vm | stray_div;

    always #5 clk = ~clk;

    softmax_sequencer #(.DATA_SIZE(32), .N_DATA(N), .TIMEOUT(TO)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start_i),
        .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
        .exp_data_o(exp_data_o), .exp_start_o(exp_start_o),
        .exp_result_i(exp_result_i), .exp_valid_i(exp_valid_i),
        .add_a_o(add_a_o), .add_b_o(add_b_o), .add_start_o(add_start_o),
        .add_result_i(add_result_i), .add_valid_i(add_valid_i),
        .div_num_o(div_num_o), .div_den_o(div_den_o), .div_start_o(div_start_o),
        .div_result_i(div_result_i), .div_valid_i(div_valid_i),
        .out_data_o(out_data_o), .out_index_o(out_index_o), .out_valid_o(out_valid_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic real fp_to_real(input logic [31:0] f);
        logic [10:0] e11;
        if (f[30:23] == 8'd0) return 0.0;
        e11 = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e11, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_fp(input real r);
        logic [63:0] d;
        logic [23:0] m;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        m = {1'b1, d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) begin
            m = m + 24'd1;
            if (m == 24'd0) e = e + 1;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_exp(input logic [31:0] x);
        return real_to_fp($exp(fp_to_real(x)));
    endfunction
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return real_to_fp(fp_to_real(a) + fp_to_real(b));
    endfunction
    function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
        return real_to_fp(fp_to_real(a) / fp_to_real(b));
    endfunction

    // Unit models: latency counted from the start pulse; latency 0 means never answer.
    int exp_lat = 3, add_lat = 2, div_lat = 4;
    int exp_cnt = 0, add_cnt = 0, div_cnt = 0;
    logic [31:0] exp_hold = '0, add_hold = '0, div_hold = '0;

    always @(negedge clk) begin
        exp_valid_i = 1'b0;
        if (!rst_n) exp_cnt = 0;
        else if (exp_start_o) begin exp_hold = fp_exp(exp_data_o); exp_cnt = exp_lat; end
        else if (exp_cnt > 0) begin
            exp_cnt--;
            if (exp_cnt == 0) begin exp_valid_i = 1'b1; exp_result_i = exp_hold; end
        end
    end

    always @(negedge clk) begin
        add_vm = 1'b0;
        if (!rst_n) add_cnt = 0;
        else if (add_start_o) begin add_hold = fp_add(add_a_o, add_b_o); add_cnt = add_lat; end
        else if (add_cnt > 0) begin
            add_cnt--;
            if (add_cnt == 0) begin add_vm = 1'b1; add_result_i = add_hold; end
        end
    end

    always @(negedge clk) begin
        div_vm = 1'b0;
        if (!rst_n) div_cnt = 0;
        else if (div_start_o) begin div_hold = fp_div(div_num_o, div_den_o); div_cnt = div_lat; end
        else if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == 0) begin div_vm = 1'b1; div_result_i = div_hold; end
        end
    end

    typedef struct packed { logic [31:0] d; logic [7:0] i; } res_t;
    res_t        sb[$];
    res_t        sb_head;
    int          n_out = 0;
    logic [31:0] first_out = '0;
    bit          err_allowed = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid_o) begin
                if (sb.size() == 0) begin
                    check("out_unexpected", out_valid_o, 1'b0);
                end else begin
                    sb_head = sb.pop_front();
                    check("out_result", {out_index_o, out_data_o}, {sb_head.i, sb_head.d});
                end
                if (out_index_o == 8'd0) first_out = out_data_o;
                n_out++;
            end
            if (!err_allowed && error_o) check("error_spurious", error_o, 1'b0);
        end
    end

    task automatic push_expected(input logic [31:0] v [N]);
        logic [31:0] ex [N];
        logic [31:0] s;
        s = FP_ZERO;
        for (int i = 0; i < N; i++) begin
            ex[i] = fp_exp(v[i]);
            s     = fp_add(s, ex[i]);
        end
        for (int i = 0; i < N; i++) sb.push_back({fp_div(ex[i], s), 8'(i)});
    endtask

    // Returns at the negedge of the cycle right after the last accepted word.
    task automatic load_vector(input logic [31:0] v [N], input int gap, input bit stray);
        @(negedge clk);
        start_i   = 1'b1;
        stray_add = stray;
        stray_div = stray;
        @(negedge clk);
        start_i   = 1'b0;
        stray_add = 1'b0;
        stray_div = 1'b0;
        check("error_cleared_on_start", error_o, 1'b0);
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) begin
                data_valid_i = 1'b0;
                data_i       = 32'hDEAD_BEEF;
                stray_add    = stray;
                stray_div    = stray;
                @(negedge clk);
                stray_add = 1'b0;
                stray_div = 1'b0;
            end
            check("ready_in_load", data_ready_o, 1'b1);
            data_valid_i = 1'b1;
            data_i       = v[i];
            @(negedge clk);
        end
        data_valid_i = 1'b0;
        check("exp_start_after_load", {data_ready_o, exp_start_o}, 2'b01);
    endtask

    task automatic wait_done(input int bound, input int base);
        int k;
        k = 0;
        while (!done_o && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_o, 1'b1);
        check("done_with_last", {out_valid_o, out_index_o}, {1'b1, 8'(N - 1)});
        @(negedge clk);
        check("output_count", n_out - base, N);
        check("scoreboard_empty", sb.size(), 0);
        check("idle_after_done", {done_o, busy_o}, 2'b00);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {data_ready_o, exp_start_o, add_start_o, div_start_o, out_valid_o,
                     busy_o, done_o, error_o, |exp_data_o, |add_a_o, |add_b_o,
                     |div_num_o, |div_den_o, |out_data_o, |out_index_o}, 15'd0);
    endtask

    typedef struct {
        logic [31:0] x0;
        logic [31:0] dx;
        int          gap;
        int          le, la, ld;
        bit          stray;
        logic [31:0] want_first;
    } row_t;

    row_t        tbl [5];
    logic [31:0] vec [N];

    task automatic build_vec(input logic [31:0] x0, input logic [31:0] dx);
        for (int i = 0; i < N; i++) vec[i] = real_to_fp(fp_to_real(x0) + i * fp_to_real(dx));
    endtask

    initial begin
        int c0, k, nd, base, starts;

        tbl[0] = '{32'h3F80_0000, 32'h0000_0000, 0, 3, 2, 4, 1'b0, 32'h0};
        tbl[1] = '{32'h3F80_0000, 32'h0000_0000, 1, 3, 2, 4, 1'b1, 32'h0};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000, 0, 1, 1, 1, 1'b0, 32'h3DCC_CCCD};
        tbl[3] = '{32'hC000_0000, 32'h3F00_0000, 2, 2, 3, 1, 1'b0, 32'h0};
        tbl[4] = '{32'h3F00_0000, 32'hBE80_0000, 0, 5, 7, 2, 1'b1, 32'h0};

        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 5; r++) begin
            exp_lat = tbl[r].le;
            add_lat = tbl[r].la;
            div_lat = tbl[r].ld;
            build_vec(tbl[r].x0, tbl[r].dx);
            push_expected(vec);
            base = n_out;
            load_vector(vec, tbl[r].gap, tbl[r].stray);
            if (tbl[r].stray) begin
                @(negedge clk);
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
                check("start_ignored_busy", {data_ready_o, busy_o}, 2'b01);
            end
            wait_done(1500, base);
            if (tbl[r].want_first != 32'h0) check("first_result", first_out, tbl[r].want_first);
        end

        // Exp answers in the last cycle before expiry: must proceed, not error.
        exp_lat = 15; add_lat = 2; div_lat = 4;
        build_vec(32'h3F80_0000, 32'h0);
        push_expected(vec);
        base = n_out;
        load_vector(vec, 0, 1'b0);
        c0 = cyc;
        k  = 0;
        while (!add_start_o && k < 40) begin @(negedge clk); k++; end
        check("acc_issue_after_late_exp", cyc - c0, 16);
        check("no_error_late_exp", error_o, 1'b0);
        wait_done(3000, base);

        // Silent exp unit: watchdog expiry.
        exp_lat     = 0;
        err_allowed = 1'b1;
        load_vector(vec, 0, 1'b0);
        c0 = cyc;
        k  = 0;
        while (!error_o && k < 100) begin @(negedge clk); k++; end
        check("error_raised", error_o, 1'b1);
        check("error_latency", cyc - c0, TO);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_start_o || add_start_o || div_start_o) starts++;
        end
        check("no_starts_in_error", starts, 0);
        check("error_sticky", {error_o, busy_o}, 2'b10);
        exp_lat = 3;
        push_expected(vec);
        base = n_out;
        load_vector(vec, 0, 1'b0);
        err_allowed = 1'b0;
        wait_done(1500, base);

        // Asynchronous reset during DIV_WAIT of element 4.
        exp_lat = 3; add_lat = 2; div_lat = 3;
        build_vec(32'hC000_0000, 32'h3F00_0000);
        push_expected(vec);
        base = n_out;
        load_vector(vec, 0, 1'b0);
        nd = 0;
        k  = 0;
        while (nd < 5 && k < 1500) begin
            @(negedge clk);
            k++;
            if (div_start_o) nd++;
        end
        check("reached_div_idx4", nd, 5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset_outputs");
        check("outputs_before_reset", n_out - base, 4);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        build_vec(32'h3F00_0000, 32'hBE80_0000);
        push_expected(vec);
        base = n_out;
        load_vector(vec, 1, 1'b0);
        wait_done(1500, base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
